// File: rtl/serial_subtractor_64bit.sv
// serial_subtractor_64bit: multi-cycle ripple-borrow subtractor.
// Computes diff = in1 - in2 - b_in, CHUNK bits per clock, LSB chunk first.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    request handshake; in1, in2, b_in captured on accept
//   out_valid/out_ready  result handshake; diff, b_out, ovf held while valid
module serial_subtractor_64bit #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             brw_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             b_out_q;
    logic             ovf_q;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CHUNK:0]   sub;
    logic             last;
    int               base;

    // Current chunk: an extra top bit on the difference is the borrow out.
    always_comb begin
        base = int'(cnt_q) * CHUNK;
        a_sh = a_q >> base;
        b_sh = b_q >> base;
        sub  = {1'b0, a_sh[CHUNK-1:0]}
             - {1'b0, b_sh[CHUNK-1:0]}
             - {{CHUNK{1'b0}}, brw_q};
        last = (cnt_q == CW'(NCHUNK - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == IDLE) begin
            if (in_valid) begin
                a_q   <= in1;
                b_q   <= in2;
                brw_q <= b_in;
                cnt_q <= '0;
            end
        end else if (state_q == BUSY) begin
            diff_q[base +: CHUNK] <= sub[CHUNK-1:0];
            brw_q <= sub[CHUNK];
            if (last) begin
                b_out_q <= sub[CHUNK];
                // Top chunk's MSB is the new diff sign bit.
                ovf_q   <= (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                         & (a_q[WIDTH-1] ^ sub[CHUNK-1]);
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Gated by rst_n so no request is offered while reset is held.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign b_out     = b_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_64bit.sv
// tb_serial_subtractor_64bit: directed and random checks of the
// serial subtractor against an arithmetic reference model.
module tb_serial_subtractor_64bit;

    localparam int W   = 64;
    localparam int LAT = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         b_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         b_out;
    logic         ovf;

    serial_subtractor_64bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   n_checks  = 0;
    int   n_err     = 0;
    int   cyc       = 0;
    int   n_acc     = 0;
    int   n_res     = 0;
    int   n_flush   = 0;
    bit   seen      = 0;
    bit   rand_rdy  = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic bi);
        exp_t       e;
        logic [W:0] r;
        r    = {1'b0, a} - {1'b0, b} - (W + 1)'(bi);
        e.d  = r[W-1:0];
        e.bo = r[W];
        e.ov = (a[W-1] ^ b[W-1]) & (a[W-1] ^ e.d[W-1]);
        e.acc = 0;
        return e;
    endfunction

    // Scoreboard: push on accept, compare while valid, pop on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_flush += q.size();
            q.delete();
            seen = 0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("sb_diff", diff, q[0].d);
                    chk("sb_b_out", 64'(b_out), 64'(q[0].bo));
                    chk("sb_ovf", 64'(ovf), 64'(q[0].ov));
                    if (!seen) begin
                        chk("sb_latency", 64'(cyc - q[0].acc), 64'(LAT));
                        seen = 1;
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_res++;
                        seen = 0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e = model(in1, in2, b_in);
                e.acc = cyc + 1;
                q.push_back(e);
                n_acc++;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi);
        int t;
        in1 = a;
        in2 = b;
        b_in = bi;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in1 = $urandom;
        in2 = $urandom;
    endtask

    task automatic wait_result();
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) chk("result_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bi, input logic [W-1:0] ed,
                          input logic ebo, input logic eov,
                          input string name);
        send(a, b, bi);
        wait_result();
        chk({name, "_diff"}, diff, ed);
        chk({name, "_b_out"}, 64'(b_out), 64'(ebo));
        chk({name, "_ovf"}, 64'(ovf), 64'(eov));
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] d0;
    logic         bo0;
    logic         ov0;
    exp_t         m;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in1 = '0;
        in2 = '0;
        b_in = 1'b0;
        out_ready = 1'b1;

        // Pin the reference model with hand-computed values.
        m = model(64'd98345672198765, 64'd12765438912345, 1'b0);
        chk("model_t1", m.d, 64'd85580233286420);
        m = model(64'd0, 64'd1, 1'b0);
        chk("model_t2", {m.d[62:0], m.bo}, 64'hFFFF_FFFF_FFFF_FFFF);
        m = model(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("model_t3", {m.d[63:2], m.bo, m.ov},
            64'h8000_0000_0000_0003);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_diff", diff, 64'd0);
        chk("rst_b_out", 64'(b_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        run_op(64'd98345672198765, 64'd12765438912345, 1'b0,
               64'd85580233286420, 1'b0, 1'b0, "t1");
        run_op(64'd0, 64'd1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, "t2a");
        run_op(64'd5, 64'd5, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, "t2b");
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, "t3a");
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
               64'h8000_0000_0000_0000, 1'b1, 1'b1, "t3b");

        // Backpressure in DONE.
        out_ready = 1'b0;
        send(64'd1000, 64'd1, 1'b1);
        wait_result();
        d0 = diff;
        bo0 = b_out;
        ov0 = ovf;
        chk("bp_diff", d0, 64'd998);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in1 = 64'd77;
            in2 = 64'd11;
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold", {diff[61:0], b_out, ovf}, {d0[61:0], bo0, ov0});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of BUSY.
        send(64'd500, 64'd123, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_diff", diff, 64'd0);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(64'd10, 64'd3, 1'b0, 64'd7, 1'b0, 1'b0, "t5");

        // Random sweep with out_ready toggling.
        rand_rdy = 1;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: a = '0;
                1: b = '1;
                2: a = 64'h8000_0000_0000_0000;
                3: b = a;
                default: ;
            endcase
            send(a, b, 1'($urandom_range(0, 1)));
        end
        for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
        rand_rdy = 0;
        #2;
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("handshake_count", 64'(n_res), 64'(n_acc - n_flush));
        chk("flush_count", 64'(n_flush), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
